grid_sequencer: RTL
===================

// Module: grid_sequencer
// PURPOSE
//  Sequencing controller for the 160x120 projectile shifter grid. Generates the periodic
//  shift strobe, converts player shoot requests into single-cycle column load strobes
//  with cooldown, and issues the grid-clear strobe at game start.
//  Sits between the input/switch logic and the grid datapath.
//  Sole owner of the grid's shift, load and clear controls.
// PARAMETERS
//  GRID_COLS     160        number of columns; valid load_col is 0..GRID_COLS-1
//  SHIFT_PERIOD  3125000    clock cycles between shift strobes (>=2)
//  COOLDOWN      1000000    cycles after a load before the next shot is accepted (>=1)
//  CNT_W         28         width of period/cooldown counters
// PORTS
//  clock        in   1   system clock, all logic on posedge
//  reset_n      in   1   asynchronous active-low reset
//  start_game   in   1   level; rising edge starts/restarts a game
//  pause        in   1   level; high freezes shifting and shooting while in RUN
//  shoot        in   1   level; player shoot request (already synchronised)
//  user_x       in   8   player column
//  grid_clear   out  1   1-cycle strobe: clear all grid bits
//  shift_en     out  1   1-cycle strobe: shift every column by one row
//  load_en      out  1   1-cycle strobe: load a 1 into row 0 of load_col
//  load_col     out  8   column for load_en; valid only while load_en=1
//  running      out  1   high in RUN state
//  shots_fired  out  16  saturating count of issued load_en strobes this game
// BEHAVIOUR
//  Reset: state=IDLE; all strobes 0; load_col=0; running=0; shots_fired=0; counters 0.
//  FSM (grid_seq_state_t): IDLE -> CLEAR on start_game rising edge.
//   CLEAR: one cycle; grid_clear=1; period counter loaded SHIFT_PERIOD-1; cooldown=0;
//     shots_fired=0; -> RUN.
//   RUN: pause=1 -> PAUSED; start_game rising edge -> CLEAR (restart from any non-IDLE state).
//   PAUSED: counters hold; no strobes; shoot edges ignored; pause=0 -> RUN.
//  Shift: in RUN, period counter decrements each cycle; at 0 it reloads SHIFT_PERIOD-1
//   and shift_en=1 that cycle. The first shift_en comes exactly SHIFT_PERIOD cycles
//   after the CLEAR cycle.
//  Shoot: rising edge of shoot in RUN with cooldown==0 and user_x<GRID_COLS sets a
//   pending request and latches user_x. Out-of-range columns are dropped; edges during
//   cooldown are dropped, not queued.
//  Issue: a pending request issues load_en on the next cycle in which shift_en=0.
//   Latency from shoot edge to load_en is 1 cycle, or 2 if the issue cycle collides with
//   shift_en. load_en and shift_en are never high in the same cycle.
//   On issue: cooldown=COOLDOWN; shots_fired+=1, saturating at 16'hFFFF.
//  Cooldown decrements 1/cycle in RUN only. A pending request survives entry to PAUSED
//   and issues after resume.
//  Strobes are mutually exclusive: grid_clear, shift_en, load_en.
//  reset_n low at any time, including mid-cooldown or pending: immediate return to
//   reset values.
// CONFIGURATION
//  AUTO_FIRE_EN defined: while shoot is held high in RUN, a new request is raised
//   automatically each time cooldown reaches 0 (same rules as an edge).
//  AUTO_FIRE_EN undefined: only a 0->1 edge of shoot raises a request; holding has no effect.
// STRUCTURE
//  Package grid_seq_pkg:
//   - grid_seq_state_t {IDLE, CLEAR, RUN, PAUSED}
//   - GRID_COLS_DEF=160, GRID_ROWS_DEF=120
//  Sub-module tick_divider (CNT_W, PERIOD):
//   - ports: clock, reset_n, enable, restart
//   - output tick: 1-cycle strobe every PERIOD enabled cycles; generates shift_en.
//  Edge detect, FSM, cooldown and pending logic stay in grid_sequencer.
// TESTING (SHIFT_PERIOD=8, COOLDOWN=5, GRID_COLS=160)
//  1 Reset, then start_game 0->1: grid_clear=1 for exactly 1 cycle; running=1 next cycle;
//    shift_en every 8 cycles, first at 8 cycles after CLEAR.
//  2 shoot edge, user_x=42, no shift collision: load_en=1, load_col=42 one cycle later;
//    shots_fired=1; second edge 3 cycles later is dropped.
//  3 shoot edge timed so the issue cycle has shift_en=1: load_en follows 1 cycle after
//    shift_en; never coincident.
//  4 user_x=160 with shoot edge: no load_en; shots_fired unchanged.
//  5 pause=1 for 20 cycles mid-run: no strobes and counters frozen; after pause=0,
//    next shift_en occurs at the remaining count.
//  6 shoot held 30 cycles: AUTO_FIRE_EN gives load_en every 6 cycles (1 issue + 5 cooldown);
//    without AUTO_FIRE_EN exactly one load_en. reset_n low mid-cooldown: all outputs
//    return to reset values immediately.

Source files
------------

// File: rtl/grid_seq_pkg.sv
// rtl/grid_seq_pkg.sv - shared state type and grid geometry defaults for the grid sequencer
package grid_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    RUN    = 2'd2,
    PAUSED = 2'd3
  } grid_seq_state_t;

  localparam int GRID_COLS_DEF = 160;
  localparam int GRID_ROWS_DEF = 120;

endpackage

// File: rtl/grid_sequencer_tick_divider.sv
// rtl/grid_sequencer_tick_divider.sv - period counter producing one tick every PERIOD enabled cycles
module tick_divider #(
  parameter int CNT_W  = 28,
  parameter int PERIOD = 3125000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Tick is combinational so the owner can register it alongside its other strobes
  // and arbitrate against it in the same cycle.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (restart) begin
      cnt_d = RELOAD;
    end else if (enable) begin
      if (cnt_q == '0) begin
        cnt_d = RELOAD;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q - ONE;
      end
    end
  end

  // Counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/grid_sequencer.sv
// rtl/grid_sequencer.sv - shift/load/clear strobe sequencer for the projectile grid (optional AUTO_FIRE_EN)
module grid_sequencer
  import grid_seq_pkg::*;
#(
  parameter int GRID_COLS    = GRID_COLS_DEF,
  parameter int SHIFT_PERIOD = 3125000,
  parameter int COOLDOWN     = 1000000,
  parameter int CNT_W        = 28
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start_game,
  input  logic        pause,
  input  logic        shoot,
  input  logic [7:0]  user_x,
  output logic        grid_clear,
  output logic        shift_en,
  output logic        load_en,
  output logic [7:0]  load_col,
  output logic        running,
  output logic [15:0] shots_fired
);

  localparam logic [CNT_W-1:0] COOLDOWN_LD = CNT_W'(COOLDOWN);
  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
  localparam logic [8:0]       COL_LIMIT   = 9'(GRID_COLS);

  grid_seq_state_t  state_q, state_d;
  logic             start_prev_q, start_prev_d;
  logic             shoot_prev_q, shoot_prev_d;
  logic             pending_q, pending_d;
  logic [7:0]       pend_col_q, pend_col_d;
  logic [CNT_W-1:0] cooldown_q, cooldown_d;
  logic [15:0]      shots_q, shots_d;
  logic             grid_clear_q, grid_clear_d;
  logic             shift_en_q, shift_en_d;
  logic             load_en_q, load_en_d;
  logic [7:0]       load_col_q, load_col_d;
  logic             running_q, running_d;

  logic start_rise, shoot_req, col_ok, run_en, restart, tick, new_req, issue;

  assign start_rise = start_game & ~start_prev_q;
  assign col_ok     = {1'b0, user_x} < COL_LIMIT;

`ifdef AUTO_FIRE_EN
  assign shoot_req = shoot;
`else
  assign shoot_req = shoot & ~shoot_prev_q;
`endif

  // Next-state decode; a start edge restarts the game from any state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_rise) state_d = CLEAR;
      CLEAR:   state_d = start_rise ? CLEAR : RUN;
      RUN:     if (start_rise) state_d = CLEAR; else if (pause) state_d = PAUSED;
      PAUSED:  if (start_rise) state_d = CLEAR; else if (!pause) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Everything advances on edges that land in RUN, so pausing freezes all counters.
  assign run_en  = (state_d == RUN);
  assign restart = (state_d == CLEAR);

  tick_divider #(
    .CNT_W  (CNT_W),
    .PERIOD (SHIFT_PERIOD)
  ) u_shift_div (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (run_en),
    .restart (restart),
    .tick    (tick)
  );

  // A request that collides with a shift stays pending and issues one cycle later.
  assign new_req = run_en & shoot_req & (cooldown_q == '0) & ~pending_q & col_ok;
  assign issue   = run_en & (pending_q | new_req) & ~tick;

  // Shot bookkeeping and registered strobe values.
  always_comb begin
    start_prev_d = start_game;
    shoot_prev_d = shoot;
    pending_d    = pending_q;
    pend_col_d   = new_req ? user_x : pend_col_q;
    cooldown_d   = cooldown_q;
    shots_d      = shots_q;
    if (restart) begin
      pending_d  = 1'b0;
      cooldown_d = '0;
      shots_d    = 16'd0;
    end else begin
      if (issue) begin
        pending_d  = 1'b0;
        cooldown_d = COOLDOWN_LD;
        if (shots_q != 16'hFFFF) shots_d = shots_q + 16'd1;
      end else begin
        if (new_req) pending_d = 1'b1;
        if (run_en && cooldown_q != '0) cooldown_d = cooldown_q - ONE;
      end
    end
    grid_clear_d = restart;
    shift_en_d   = tick;
    load_en_d    = issue;
    load_col_d   = issue ? (pending_q ? pend_col_q : user_x) : 8'd0;
    running_d    = run_en;
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      start_prev_q <= 1'b0;
      shoot_prev_q <= 1'b0;
      pending_q    <= 1'b0;
      pend_col_q   <= 8'd0;
      cooldown_q   <= '0;
      shots_q      <= 16'd0;
      grid_clear_q <= 1'b0;
      shift_en_q   <= 1'b0;
      load_en_q    <= 1'b0;
      load_col_q   <= 8'd0;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_prev_d;
      shoot_prev_q <= shoot_prev_d;
      pending_q    <= pending_d;
      pend_col_q   <= pend_col_d;
      cooldown_q   <= cooldown_d;
      shots_q      <= shots_d;
      grid_clear_q <= grid_clear_d;
      shift_en_q   <= shift_en_d;
      load_en_q    <= load_en_d;
      load_col_q   <= load_col_d;
      running_q    <= running_d;
    end
  end

  assign grid_clear  = grid_clear_q;
  assign shift_en    = shift_en_q;
  assign load_en     = load_en_q;
  assign load_col    = load_col_q;
  assign running     = running_q;
  assign shots_fired = shots_q;

endmodule
